// File: rtl/imm_ext_stage_ctrl.sv
// Decode-stage controller for the shared immediate extender: opcode decode, D/E capture of the extended immediate.
// Latency: ext_op/ext_imm16/illegal_d combinational from instr_d; imm_e and the other _e outputs one cycle later.
// Backpressure: stall holds the D/E register, flush inserts a bubble and wins over stall.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   instr_d, valid_d      D-stage instruction and its valid flag
//   stall, flush          hazard-unit hold / bubble requests for the D/E register
//   ext_imm16, ext_op     drive the external extender; ext_out is its result
//   imm_e, use_imm_e,     registered E-stage immediate, B-operand select,
//   ext_op_e, valid_e     extension mode and slot-valid flag
//   illegal_d             valid D-stage instruction whose opcode is not decoded
//   stall_cnt             saturating count of cycles stalled without a flush
module imm_ext_stage_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            instr_d,
    input  logic                   valid_d,
    input  logic                   stall,
    input  logic                   flush,
    output logic [15:0]            ext_imm16,
    output logic [1:0]             ext_op,
    input  logic [31:0]            ext_out,
    output logic [31:0]            imm_e,
    output logic                   use_imm_e,
    output logic [1:0]             ext_op_e,
    output logic                   valid_e,
    output logic                   illegal_d,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    logic [5:0] op_d;
    logic       use_imm;
    logic       legal;

    assign op_d      = instr_d[31:26];
    assign ext_imm16 = instr_d[15:0];

    always_comb begin
        ext_op  = EXT_ZERO;
        use_imm = 1'b0;
        legal   = 1'b1;
        case (op_d)
            // andi, ori, xori
            6'h0C, 6'h0D, 6'h0E: begin
                ext_op  = EXT_ZERO;
                use_imm = 1'b1;
            end
            // addi..sltiu, loads, stores
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
            6'h28, 6'h29, 6'h2B: begin
                ext_op  = EXT_SIGN;
                use_imm = 1'b1;
            end
            // lui
            6'h0F: begin
                ext_op  = EXT_LUI;
                use_imm = 1'b1;
            end
            // branches: offset is sign-extended but consumed by the branch unit, not the ALU
            6'h01, 6'h04, 6'h05, 6'h06, 6'h07: begin
                ext_op  = EXT_SIGN;
                use_imm = 1'b0;
            end
            // R-type, j, jal
            6'h00, 6'h02, 6'h03: begin
                ext_op  = EXT_ZERO;
                use_imm = 1'b0;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    assign illegal_d = valid_d & ~legal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imm_e     <= '0;
            use_imm_e <= 1'b0;
            ext_op_e  <= EXT_ZERO;
            valid_e   <= 1'b0;
        end else if (flush) begin
            imm_e     <= '0;
            use_imm_e <= 1'b0;
            ext_op_e  <= EXT_ZERO;
            valid_e   <= 1'b0;
        end else if (!stall) begin
            valid_e <= valid_d;
            if (valid_d) begin
                // Illegal opcodes still flow down with use_imm=0; the trap is raised downstream.
                imm_e     <= ext_out;
                use_imm_e <= use_imm;
                ext_op_e  <= ext_op;
            end else begin
                imm_e     <= '0;
                use_imm_e <= 1'b0;
                ext_op_e  <= EXT_ZERO;
            end
        end
    end

    // A stall that coincides with a flush is not a held cycle, so it is not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && !flush && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_ext_stage_ctrl.sv
module tb_imm_ext_stage_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] instr_d;
    logic        valid_d;
    logic        stall;
    logic        flush;
    logic [15:0] ext_imm16;
    logic [1:0]  ext_op;
    logic [31:0] ext_out;
    logic [31:0] imm_e;
    logic        use_imm_e;
    logic [1:0]  ext_op_e;
    logic        valid_e;
    logic        illegal_d;
    logic [15:0] stall_cnt;

    // Second instance with a narrow counter for the saturation check.
    logic [15:0] s_ext_imm16;
    logic [1:0]  s_ext_op;
    logic [31:0] s_imm_e;
    logic        s_use_imm_e;
    logic [1:0]  s_ext_op_e;
    logic        s_valid_e;
    logic        s_illegal_d;
    logic [3:0]  s_stall_cnt;
    logic [31:0] s_ext_out;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic        v;
        logic [31:0] imm;
        logic        use_imm;
        logic [1:0]  op;
    } exp_t;

    exp_t sb[$];

    imm_ext_stage_ctrl #(.STALL_CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .instr_d(instr_d), .valid_d(valid_d),
        .stall(stall), .flush(flush), .ext_imm16(ext_imm16), .ext_op(ext_op),
        .ext_out(ext_out), .imm_e(imm_e), .use_imm_e(use_imm_e),
        .ext_op_e(ext_op_e), .valid_e(valid_e), .illegal_d(illegal_d),
        .stall_cnt(stall_cnt)
    );

    imm_ext_stage_ctrl #(.STALL_CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .instr_d(instr_d), .valid_d(valid_d),
        .stall(stall), .flush(flush), .ext_imm16(s_ext_imm16), .ext_op(s_ext_op),
        .ext_out(s_ext_out), .imm_e(s_imm_e), .use_imm_e(s_use_imm_e),
        .ext_op_e(s_ext_op_e), .valid_e(s_valid_e), .illegal_d(s_illegal_d),
        .stall_cnt(s_stall_cnt)
    );

    // Behavioural model of the shared extender.
    function automatic logic [31:0] ext_model(input logic [15:0] imm, input logic [1:0] op);
        case (op)
            2'd0:    return {16'h0000, imm};
            2'd1:    return {{16{imm[15]}}, imm};
            2'd2:    return {imm, 16'h0000};
            default: return 32'h0;
        endcase
    endfunction

    assign ext_out   = ext_model(ext_imm16, ext_op);
    assign s_ext_out = ext_model(s_ext_imm16, s_ext_op);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive one instruction (caller has already aligned to a negedge), check the
    // combinational decode, and queue the expected E-stage capture.
    task automatic drive(input string name, input logic [31:0] ins, input logic vld,
                         input logic [1:0] exp_op, input logic exp_ill,
                         input logic [31:0] exp_imm, input logic exp_use);
        exp_t e;
        instr_d = ins;
        valid_d = vld;
        stall   = 1'b0;
        flush   = 1'b0;
        #1;
        check({name, "_ext_op"}, 32'(ext_op), 32'(exp_op));
        check({name, "_illegal"}, 32'(illegal_d), 32'(exp_ill));
        e.v       = vld;
        e.imm     = vld ? exp_imm : 32'h0;
        e.use_imm = vld ? exp_use : 1'b0;
        e.op      = vld ? exp_op : 2'd0;
        sb.push_back(e);
    endtask

    // Monitor: pops on every edge that captures (no reset, no flush, no stall);
    // on flush edges the slot must be an empty bubble.
    initial begin
        logic r, st, fl;
        exp_t e;
        forever begin
            @(posedge clk);
            r  = reset;
            st = stall;
            fl = flush;
            #1;
            if (r) continue;
            if (fl) begin
                check("flush_valid_e", 32'(valid_e), 32'h0);
                check("flush_imm_e", imm_e, 32'h0);
                check("flush_use_imm_e", 32'(use_imm_e), 32'h0);
                check("flush_ext_op_e", 32'(ext_op_e), 32'h0);
            end else if (!st) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(sb.size()), 32'h1);
                end else begin
                    e = sb.pop_front();
                    check("mon_valid_e", 32'(valid_e), 32'(e.v));
                    check("mon_imm_e", imm_e, e.imm);
                    check("mon_use_imm_e", 32'(use_imm_e), 32'(e.use_imm));
                    check("mon_ext_op_e", 32'(ext_op_e), 32'(e.op));
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        instr_d = 32'h0;
        valid_d = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_imm_e", imm_e, 32'h0);
        check("rst_valid_e", 32'(valid_e), 32'h0);
        check("rst_use_imm_e", 32'(use_imm_e), 32'h0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'h0);

        // Immediate-using instructions.
        reset = 1'b0;
        drive("ori",  32'h3421F0F0, 1'b1, 2'd0, 1'b0, 32'h0000F0F0, 1'b1);
        check("ori_imm16", 32'(ext_imm16), 32'h0000F0F0);
        @(negedge clk); drive("lw",   32'h8C22FFFC, 1'b1, 2'd1, 1'b0, 32'hFFFFFFFC, 1'b1);
        @(negedge clk); drive("lui",  32'h3C011234, 1'b1, 2'd2, 1'b0, 32'h12340000, 1'b1);
        @(negedge clk); drive("andi", 32'h30008001, 1'b1, 2'd0, 1'b0, 32'h00008001, 1'b1);
        // Non-immediate instructions.
        @(negedge clk); drive("rtype", 32'h00221820, 1'b1, 2'd0, 1'b0, 32'h00001820, 1'b0);
        @(negedge clk); drive("beq",   32'h1022FFFE, 1'b1, 2'd1, 1'b0, 32'hFFFFFFFE, 1'b0);
        @(negedge clk); drive("ill_v", 32'hFC001234, 1'b1, 2'd0, 1'b1, 32'h00001234, 1'b0);
        @(negedge clk); drive("ill_n", 32'hFC001234, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);

        // Capture addi, then hold for three stalled cycles with changing instr_d.
        @(negedge clk); drive("addi", 32'h2001FFFF, 1'b1, 2'd1, 1'b0, 32'hFFFFFFFF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stall   = 1'b1;
            instr_d = 32'h3421F0F0 + 32'(i);
            valid_d = 1'b1;
            @(posedge clk); #1;
            check("stall_hold_imm_e", imm_e, 32'hFFFFFFFF);
            check("stall_hold_valid_e", 32'(valid_e), 32'h1);
        end
        check("stall_cnt_3", 32'(stall_cnt), 32'd3);

        // Stall and flush together: bubble, counter unchanged.
        @(negedge clk);
        stall = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        check("stall_cnt_flush", 32'(stall_cnt), 32'd3);

        // Saturation: narrow counter reaches 15 after 12 more stalls and stays.
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i == 11) check("sat_reach_15", 32'(s_stall_cnt), 32'd15);
        end
        check("sat_hold_15", 32'(s_stall_cnt), 32'd15);
        check("wide_cnt_23", 32'(stall_cnt), 32'd23);

        // Asynchronous reset mid-stall, between edges.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_imm_e", imm_e, 32'h0);
        check("arst_valid_e", 32'(valid_e), 32'h0);
        check("arst_stall_cnt", 32'(stall_cnt), 32'h0);
        check("arst_sat_cnt", 32'(s_stall_cnt), 32'h0);

        // First edge after release captures the current instruction.
        @(negedge clk);
        reset = 1'b0;
        drive("ori_post", 32'h3421F0F0, 1'b1, 2'd0, 1'b0, 32'h0000F0F0, 1'b1);
        @(negedge clk);
        drive("idle", 32'h0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
